// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the MIPS multiply/divide sequencer: operation
// encodings, controller state encoding, iteration-step mode and the helper
// that sizes the iteration counter.
// -----------------------------------------------------------------------------
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   // Operation encodings as presented on the op input.
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREP,
      ST_RUN,
      ST_FIX
   } md_state_e;

   // Selects what the shared iteration datapath does this cycle.
   typedef enum logic {
      MODE_MUL,
      MODE_DIV
   } step_mode_e;

   // Iteration counter width: enough bits to count 0 .. w-1.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the multiply/divide datapath, built around a
// single WIDTH+1 bit adder/subtractor.
//   Multiply (shift-add, LSB first): {acc, sh} holds {partial product,
//     remaining multiplier}; add the operand when sh[0] is set, then shift the
//     whole pair right by one.
//   Divide (restoring): {acc, sh} holds {partial remainder, dividend/quotient};
//     shift left by one, trial-subtract the operand from the top WIDTH+1 bits
//     and shift the quotient bit into sh[0].
// Ports:
//   i_mode  : MODE_MUL or MODE_DIV
//   i_acc   : accumulator / partial remainder
//   i_sh    : multiplier / dividend-quotient shift register
//   i_opnd  : multiplicand / divisor magnitude
//   o_acc   : next accumulator
//   o_sh    : next shift register
// -----------------------------------------------------------------------------
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  step_mode_e       i_mode,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_sh,
   input  logic [WIDTH-1:0] i_opnd,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_sh
);

   logic [WIDTH:0] w_a;
   logic [WIDTH:0] w_b;
   logic [WIDTH:0] w_cin;
   logic [WIDTH:0] w_sum;
   logic           w_qbit;

   // NOTE: every signal driven in an always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      w_a   = {1'b0, i_acc};
      w_b   = '0;
      w_cin = '0;
      if (i_mode == MODE_DIV) begin
         // a - b computed as a + ~b + 1 on the shared adder.
         w_a   = {i_acc, i_sh[WIDTH-1]};
         w_b   = ~{1'b0, i_opnd};
         w_cin = {{WIDTH{1'b0}}, 1'b1};
      end else if (i_sh[0]) begin
         w_b = {1'b0, i_opnd};
      end
   end

   assign w_sum = w_a + w_b + w_cin;

   // The partial remainder is always below the divisor, so the shifted value is
   // below twice the divisor and a clear top bit of the difference means the
   // subtraction did not go negative (this also covers a set top bit in w_a).
   assign w_qbit = ~w_sum[WIDTH];

   always_comb begin
      o_acc = w_sum[WIDTH:1];
      o_sh  = {w_sum[0], i_sh[WIDTH-1:1]};
      if (i_mode == MODE_DIV) begin
         o_acc = w_qbit ? w_sum[WIDTH-1:0] : w_a[WIDTH-1:0];
         o_sh  = {i_sh[WIDTH-2:0], w_qbit};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. Owns the architectural
// HI/LO registers and drives muldiv_step for WIDTH iterations per operation.
// Sequence: IDLE -> PREP (signs, magnitudes) -> RUN (WIDTH steps) -> FIX
// (sign fix / divide-by-zero override, HI/LO write) -> IDLE.
// Ports:
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_start, i_op         : operation request (sampled in IDLE only) and opcode
//   i_rs_val, i_rt_val    : multiplicand/dividend, multiplier/divisor
//   i_hi_we, i_lo_we      : MTHI/MTLO write enables (IDLE only)
//   i_wdata               : MTHI/MTLO data
//   o_busy                : state is not IDLE
//   o_done                : one-cycle pulse after HI/LO were written by an op
//   o_div_zero            : pulses with o_done when the divisor was zero
//   o_hi, o_lo            : architectural HI/LO
// -----------------------------------------------------------------------------
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_rs_val,
   input  logic [WIDTH-1:0] i_rt_val,
   input  logic             i_hi_we,
   input  logic             i_lo_we,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_zero,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e          r_state;
   md_state_e          w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   md_op_e             r_op;
   logic [WIDTH-1:0]   r_rs;
   logic [WIDTH-1:0]   r_rt;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_sh;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_neg_q;      // product / quotient must be negated
   logic               r_neg_r;      // remainder must be negated
   logic               r_div_zero;   // divisor was zero for this op
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic               r_dz_pulse;

   logic               w_is_div;
   logic               w_signed;
   step_mode_e         w_mode;
   logic [WIDTH-1:0]   w_rs_abs;
   logic [WIDTH-1:0]   w_rt_abs;
   logic [WIDTH-1:0]   w_acc_nxt;
   logic [WIDTH-1:0]   w_sh_nxt;
   logic [2*WIDTH-1:0] w_prod_f;
   logic [WIDTH-1:0]   w_quo_f;
   logic [WIDTH-1:0]   w_rem_f;

   assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
   assign w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
   assign w_mode   = w_is_div ? MODE_DIV : MODE_MUL;

   // Magnitudes for signed ops; -2^(WIDTH-1) maps onto itself, which is the
   // correct unsigned magnitude.
   assign w_rs_abs = (w_signed && r_rs[WIDTH-1]) ? -r_rs : r_rs;
   assign w_rt_abs = (w_signed && r_rt[WIDTH-1]) ? -r_rt : r_rt;

   assign w_prod_f = r_neg_q ? -{r_acc, r_sh} : {r_acc, r_sh};
   assign w_quo_f  = r_neg_q ? -r_sh  : r_sh;
   assign w_rem_f  = r_neg_r ? -r_acc : r_acc;

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_mode (w_mode),
      .i_acc  (r_acc),
      .i_sh   (r_sh),
      .i_opnd (r_opnd),
      .o_acc  (w_acc_nxt),
      .o_sh   (w_sh_nxt)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (i_start) w_state_nxt = ST_PREP;
         ST_PREP: w_state_nxt = ST_RUN;
         ST_RUN:  if (r_cnt == CNT_LAST) w_state_nxt = ST_FIX;
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- datapath and HI/LO ----------------
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the values from before the edge.
   // NOTE: the working registers are reset along with HI/LO even though they
   // are reloaded before use; an abort then leaves no stale operand behind.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt      <= '0;
         r_op       <= OP_MULT;
         r_rs       <= '0;
         r_rt       <= '0;
         r_acc      <= '0;
         r_sh       <= '0;
         r_opnd     <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
         r_dz_pulse <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_dz_pulse <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  // start wins over a simultaneous MTHI/MTLO
                  r_op <= md_op_e'(i_op);
                  r_rs <= i_rs_val;
                  r_rt <= i_rt_val;
               end else begin
                  if (i_hi_we) r_hi <= i_wdata;
                  if (i_lo_we) r_lo <= i_wdata;
               end
            end
            ST_PREP: begin
               r_neg_q    <= w_signed & (r_rs[WIDTH-1] ^ r_rt[WIDTH-1]);
               r_neg_r    <= w_signed & r_rs[WIDTH-1];
               r_div_zero <= w_is_div && (r_rt == '0);
               r_acc      <= '0;
               r_sh       <= w_is_div ? w_rs_abs : w_rt_abs;
               r_opnd     <= w_is_div ? w_rt_abs : w_rs_abs;
               r_cnt      <= '0;
            end
            ST_RUN: begin
               r_acc <= w_acc_nxt;
               r_sh  <= w_sh_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            ST_FIX: begin
               if (!w_is_div) begin
                  r_hi <= w_prod_f[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_f[WIDTH-1:0];
               end else if (r_div_zero) begin
                  r_hi <= r_rs;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_rem_f;
                  r_lo <= w_quo_f;
               end
               r_done     <= 1'b1;
               r_dz_pulse <= r_div_zero;
            end
            default: ;
         endcase
      end
   end

   assign o_busy     = (r_state != ST_IDLE);
   assign o_done     = r_done;
   assign o_div_zero = r_dz_pulse;
   assign o_hi       = r_hi;
   assign o_lo       = r_lo;

endmodule
